// File: rtl/srlatch_seq_ctrl.sv
// srlatch_seq_ctrl -- sequencer/arbiter for a bank of gated SR latches.
//
// Two requesters (A, B) issue SET / RESET / TOGGLE commands over valid/ready.
// Grant is round-robin. Each command is played out as setup (s/r driven,
// e low) -> enable pulse (e high for PULSE_CYC cycles) -> hold (e low, s/r
// still driven, done pulse). s and r are never high together, and at most
// one enable bit is high. A shadow copy of the latch values is kept; TOGGLE
// resolves its direction from the shadow at accept time.
//
// Optional feature macro: SRLATCH_READBACK_EN
//   When defined, the latch_q port exists and, in hold, the addressed latch
//   output is compared with the new shadow value. A mismatch raises err with
//   done. The shadow still takes the commanded value.
//
// Ports
//   clk                  rising-edge clock
//   rst                  synchronous active-high reset
//   a_valid/a_ready      requester A handshake
//   a_op[1:0]            00 NOP, 01 SET, 10 RESET, 11 TOGGLE
//   a_idx[IDX_W-1:0]     requester A target latch
//   b_*                  same for requester B
//   done                 1-cycle pulse when a granted command completes
//   done_id              requester of the completing command (0=A, 1=B)
//   err                  with done: bad index (or readback mismatch)
//   latch_e/s/r          per-latch enable / set / reset
//   q_shadow             expected latch values
//   latch_q              actual latch outputs (readback build only)
module srlatch_seq_ctrl #(
  parameter int N_LATCH   = 4,
  parameter int IDX_W     = 2,
  parameter int PULSE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_valid,
  output logic               a_ready,
  input  logic [1:0]         a_op,
  input  logic [IDX_W-1:0]   a_idx,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [1:0]         b_op,
  input  logic [IDX_W-1:0]   b_idx,
  output logic               done,
  output logic               done_id,
  output logic               err,
  output logic [N_LATCH-1:0] latch_e,
  output logic [N_LATCH-1:0] latch_s,
  output logic [N_LATCH-1:0] latch_r,
  output logic [N_LATCH-1:0] q_shadow
`ifdef SRLATCH_READBACK_EN
  ,
  input  logic [N_LATCH-1:0] latch_q
`endif
);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam int         CNT_W     = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam logic [N_LATCH-1:0] ONE = N_LATCH'(1);
  localparam logic [IDX_W:0]     NL  = (IDX_W+1)'(N_LATCH);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t             state_q, state_d;
  logic               prio_q;          // 0: A holds priority, 1: B
  logic [N_LATCH-1:0] shadow_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               req_q;
  logic [1:0]         op_q;
  logic [IDX_W-1:0]   idx_q;
  logic               val_q;           // value the target latch is driven to

  logic               grant_b, accept;
  logic [1:0]         in_op;
  logic [IDX_W-1:0]   in_idx;
  logic               in_val;
  logic [N_LATCH-1:0] sel;
  logic               bad_idx, drive, rb_mis, pulse_last;

  // With no requester valid the priority holder is shown ready, so an idle
  // bus advertises who would win next.
  always_comb begin
    grant_b = prio_q;
    if (a_valid || b_valid)
      grant_b = b_valid && (!a_valid || prio_q);
  end

  assign a_ready = !rst && (state_q == IDLE) && !grant_b;
  assign b_ready = !rst && (state_q == IDLE) &&  grant_b;
  assign accept  = (a_valid && a_ready) || (b_valid && b_ready);

  assign in_op   = grant_b ? b_op  : a_op;
  assign in_idx  = grant_b ? b_idx : a_idx;

  // TOGGLE direction is frozen at accept from the shadow.
  always_comb begin
    case (in_op)
      OP_SET:   in_val = 1'b1;
      OP_RESET: in_val = 1'b0;
      default:  in_val = ~(|(shadow_q & (ONE << in_idx)));
    endcase
  end

  // An out-of-range index shifts the one-hot off the end, so no latch is hit.
  assign sel        = ONE << idx_q;
  assign bad_idx    = {1'b0, idx_q} >= NL;
  assign drive      = (op_q != OP_NOP) && !bad_idx;
  assign pulse_last = (cnt_q == CNT_W'(PULSE_CYC - 1));

`ifdef SRLATCH_READBACK_EN
  assign rb_mis = drive && ((|(latch_q & sel)) != val_q);
`else
  assign rb_mis = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (in_op == OP_NOP) ? HOLD : SETUP;
      SETUP:   state_d = PULSE;
      PULSE:   if (pulse_last) state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    latch_e = '0;
    latch_s = '0;
    latch_r = '0;
    done    = 1'b0;
    err     = 1'b0;
    if (drive && (state_q != IDLE)) begin
      latch_s = val_q ? sel : '0;
      latch_r = val_q ? '0  : sel;
    end
    if (drive && (state_q == PULSE))
      latch_e = sel;
    if (state_q == HOLD) begin
      done = 1'b1;
      err  = bad_idx || rb_mis;
    end
  end

  assign done_id  = (state_q == HOLD) && req_q;
  assign q_shadow = shadow_q;

  // Control state: reset-cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == PULSE) ? cnt_q + 1'b1 : '0;
      if (accept)
        prio_q <= ~grant_b;
      if ((state_q == PULSE) && pulse_last && drive)
        shadow_q <= val_q ? (shadow_q | sel) : (shadow_q & ~sel);
    end
  end

  // Command capture: only meaningful outside IDLE, so not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_q <= grant_b;
      op_q  <= in_op;
      idx_q <= in_idx;
      val_q <= in_val;
    end
  end

endmodule

// File: tb/tb_srlatch_seq_ctrl.sv
module tb_srlatch_seq_ctrl;

  localparam int N  = 3;
  localparam int IW = 2;
  localparam int P  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [1:0]    a_op, b_op;
  logic [IW-1:0] a_idx, b_idx;
  logic          done, done_id, err;
  logic [N-1:0]  latch_e, latch_s, latch_r, q_shadow;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model state: command timeline measured in cycles since accept.
  bit           m_busy;
  int           m_t, m_hold_t;
  bit           m_req;
  logic [1:0]   m_op;
  int           m_idx;
  bit           m_val;
  logic [N-1:0] m_shadow;
  bit           m_prio;
  bit           chk_en = 1'b0;

`ifdef SRLATCH_READBACK_EN
  logic [N-1:0] latch_q;
  logic [N-1:0] force_mask = '0;
  assign latch_q = m_shadow ^ force_mask;
`endif

  srlatch_seq_ctrl #(.N_LATCH(N), .IDX_W(IW), .PULSE_CYC(P)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_idx(a_idx),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_idx(b_idx),
    .done(done), .done_id(done_id), .err(err),
    .latch_e(latch_e), .latch_s(latch_s), .latch_r(latch_r),
    .q_shadow(q_shadow)
`ifdef SRLATCH_READBACK_EN
    , .latch_q(latch_q)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_grant_b();
    if (a_valid || b_valid) return b_valid && (!a_valid || m_prio);
    return m_prio;
  endfunction

  // Model update on the active edge.
  always @(posedge clk) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_t      <= 0;
      m_shadow <= '0;
      m_prio   <= 1'b0;
    end else if (m_busy) begin
      if (m_t == m_hold_t) begin
        m_busy <= 1'b0;
      end else begin
        m_t <= m_t + 1;
        if ((m_t + 1 == m_hold_t) && (m_op != 2'b00) && (m_idx < N))
          m_shadow[m_idx] <= m_val;
      end
    end else if (m_grant_b() ? b_valid : a_valid) begin
      m_busy   <= 1'b1;
      m_t      <= 1;
      m_req    <= m_grant_b();
      m_prio   <= !m_grant_b();
      m_op     <= m_grant_b() ? b_op : a_op;
      m_idx    <= m_grant_b() ? int'(b_idx) : int'(a_idx);
      m_hold_t <= (((m_grant_b() ? b_op : a_op)) == 2'b00) ? 1 : P + 2;
      case (m_grant_b() ? b_op : a_op)
        2'b01:   m_val <= 1'b1;
        2'b10:   m_val <= 1'b0;
        default: m_val <= ((m_grant_b() ? int'(b_idx) : int'(a_idx)) < N) ?
                          !m_shadow[m_grant_b() ? int'(b_idx) : int'(a_idx)] : 1'b0;
      endcase
    end
  end

  task automatic compare_all();
    bit           sel_ok, nop, drv, setup, pulse, hold, rb;
    logic [N-1:0] sel, e_x, s_x, r_x;
    bit           ga;
    sel_ok = m_busy && (m_idx < N);
    sel    = sel_ok ? (N'(1) << m_idx) : '0;
    nop    = (m_op == 2'b00);
    drv    = m_busy && !nop && sel_ok;
    setup  = m_busy && !nop && (m_t == 1);
    pulse  = m_busy && !nop && (m_t >= 2) && (m_t <= P + 1);
    hold   = m_busy && (m_t == m_hold_t);
    e_x    = (drv && pulse) ? sel : '0;
    s_x    = (drv && (setup || pulse || hold) &&  m_val) ? sel : '0;
    r_x    = (drv && (setup || pulse || hold) && !m_val) ? sel : '0;
    rb     = 1'b0;
`ifdef SRLATCH_READBACK_EN
    if (drv) rb = (latch_q[m_idx] != m_val);
`endif
    ga = !m_grant_b();
    chk("a_ready",  32'(a_ready),  32'(!rst && !m_busy && ga));
    chk("b_ready",  32'(b_ready),  32'(!rst && !m_busy && !ga));
    chk("latch_e",  32'(latch_e),  32'(e_x));
    chk("latch_s",  32'(latch_s),  32'(s_x));
    chk("latch_r",  32'(latch_r),  32'(r_x));
    chk("done",     32'(done),     32'(hold));
    chk("done_id",  32'(done_id),  32'(hold && m_req));
    chk("err",      32'(err),      32'(hold && ((m_idx >= N) || rb)));
    chk("q_shadow", 32'(q_shadow), 32'(m_shadow));
    chk("s_and_r",  32'(latch_s & latch_r), 32'(0));
    chk("e_needs_sr", 32'(latch_e & ~(latch_s ^ latch_r)), 32'(0));
    chk("e_onehot", 32'($countones(latch_e) <= 1), 32'(1));
  endtask

  always @(negedge clk) if (chk_en) compare_all();

  // Issue up to one command per requester and run until both are served and
  // the sequencer is idle again. Tallies output activity along the way.
  task automatic run_cmd(input bit av, input logic [1:0] aop, input int aidx,
                         input bit bv, input logic [1:0] bop, input int bidx,
                         input bit glitch_b,
                         output int e_cnt, output int s_cnt, output int r_cnt,
                         output int d_cnt, output int err_cnt,
                         output int first_id, output int last_id);
    bit acc_a, acc_b, fin, gl_on, gl_done;
    e_cnt = 0; s_cnt = 0; r_cnt = 0; d_cnt = 0; err_cnt = 0;
    first_id = -1; last_id = -1;
    fin = 1'b0; gl_on = 1'b0; gl_done = 1'b0;
    a_valid = av; a_op = aop; a_idx = IW'(aidx);
    b_valid = bv; b_op = bop; b_idx = IW'(bidx);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (latch_e != '0) e_cnt++;
      if (latch_s != '0) s_cnt++;
      if (latch_r != '0) r_cnt++;
      if (done) begin
        d_cnt++;
        if (first_id < 0) first_id = int'(done_id);
        last_id = int'(done_id);
      end
      if (err) err_cnt++;
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      if (!a_valid && !b_valid && !m_busy) begin
        fin = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (acc_a) a_valid = 1'b0;
      if (acc_b || gl_on) begin b_valid = 1'b0; gl_on = 1'b0; end
      if (glitch_b && !gl_done && m_busy && !a_valid && (m_t == 2)) begin
        b_valid = 1'b1; b_op = 2'b01; b_idx = '0;
        gl_on = 1'b1; gl_done = 1'b1;
      end
    end
    if (!fin) begin
      n_vec++; n_mis++;
      $display("FAIL cmd_timeout: got busy expected idle within 40 cycles");
      a_valid = 1'b0; b_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  int ec, sc, rc, dc, erc, fid, lid;

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_op = '0; b_op = '0; a_idx = '0; b_idx = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_q_shadow", 32'(q_shadow), 32'(0));
    chk("rst_a_ready",  32'(a_ready),  32'(0));
    chk("rst_done",     32'(done),     32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_a_ready", 32'(a_ready), 32'(1));
    chk("idle_b_ready", 32'(b_ready), 32'(0));
    @(posedge clk); #1;

    // A: SET 2
    run_cmd(1, 2'b01, 2, 0, 2'b00, 0, 0, ec, sc, rc, dc, erc, fid, lid);
    chk("set2_e_cycles", 32'(ec), 32'(2));
    chk("set2_s_cycles", 32'(sc), 32'(P + 2));
    chk("set2_done",     32'(dc), 32'(1));
    chk("set2_done_id",  32'(lid), 32'(0));
    chk("set2_shadow",   32'(q_shadow), 32'(3'b100));

    // TOGGLE 2 twice
    run_cmd(1, 2'b11, 2, 0, 2'b00, 0, 0, ec, sc, rc, dc, erc, fid, lid);
    chk("tog1_r_cycles", 32'(rc), 32'(P + 2));
    chk("tog1_s_cycles", 32'(sc), 32'(0));
    chk("tog1_shadow",   32'(q_shadow), 32'(3'b000));
    run_cmd(1, 2'b11, 2, 0, 2'b00, 0, 0, ec, sc, rc, dc, erc, fid, lid);
    chk("tog2_s_cycles", 32'(sc), 32'(P + 2));
    chk("tog2_shadow",   32'(q_shadow), 32'(3'b100));

    // B: RESET 1 hands priority back to A
    run_cmd(0, 2'b00, 0, 1, 2'b10, 1, 0, ec, sc, rc, dc, erc, fid, lid);
    chk("b_reset_done_id", 32'(lid), 32'(1));
    chk("b_reset_shadow",  32'(q_shadow), 32'(3'b100));

    // A and B together: A first, then B
    run_cmd(1, 2'b01, 0, 1, 2'b01, 1, 0, ec, sc, rc, dc, erc, fid, lid);
    chk("both_first_id", 32'(fid), 32'(0));
    chk("both_last_id",  32'(lid), 32'(1));
    chk("both_dones",    32'(dc), 32'(2));
    chk("both_shadow",   32'(q_shadow), 32'(3'b111));

    // Bad index
    run_cmd(1, 2'b01, 3, 0, 2'b00, 0, 0, ec, sc, rc, dc, erc, fid, lid);
    chk("bad_e_cycles", 32'(ec), 32'(0));
    chk("bad_s_cycles", 32'(sc + rc), 32'(0));
    chk("bad_done",     32'(dc), 32'(1));
    chk("bad_err",      32'(erc), 32'(1));
    chk("bad_shadow",   32'(q_shadow), 32'(3'b111));

    // NOP: done without latch activity
    run_cmd(0, 2'b00, 0, 1, 2'b00, 2, 0, ec, sc, rc, dc, erc, fid, lid);
    chk("nop_activity", 32'(ec + sc + rc), 32'(0));
    chk("nop_done",     32'(dc), 32'(1));

    // A RESET 2 while B pulses valid mid-command (ignored)
    run_cmd(1, 2'b10, 2, 0, 2'b00, 0, 1, ec, sc, rc, dc, erc, fid, lid);
    chk("glitch_dones",  32'(dc), 32'(1));
    chk("glitch_shadow", 32'(q_shadow), 32'(3'b011));

    // Reset during PULSE
    a_valid = 1'b1; a_op = 2'b01; a_idx = 2'd2;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_e", 32'(latch_e), 32'(3'b100));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_e",      32'(latch_e), 32'(0));
    chk("post_rst_s",      32'(latch_s | latch_r), 32'(0));
    chk("post_rst_shadow", 32'(q_shadow), 32'(0));
    dc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("post_rst_no_done", 32'(dc), 32'(0));
    @(posedge clk); #1;

`ifdef SRLATCH_READBACK_EN
    force_mask = 3'b010;
    run_cmd(1, 2'b01, 1, 0, 2'b00, 0, 0, ec, sc, rc, dc, erc, fid, lid);
    chk("rb_err",    32'(erc), 32'(1));
    chk("rb_done",   32'(dc), 32'(1));
    chk("rb_shadow", 32'(q_shadow), 32'(3'b010));
    force_mask = '0;
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

endmodule
